// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Register-file execute stage; single-cycle logic/shift ops and
//                16-iteration shift-add MUL / restoring DIVU with writeback.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec_stage #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [ADDR_W-1:0] dest,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [WIDTH-1:0]  wb_data,
    output logic              busy,
    output logic              flag_z,
    output logic              flag_c
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [OP_W-1:0] c_op_add = OP_W'(0);
    localparam logic [OP_W-1:0] c_op_sub = OP_W'(1);
    localparam logic [OP_W-1:0] c_op_and = OP_W'(2);
    localparam logic [OP_W-1:0] c_op_or  = OP_W'(3);
    localparam logic [OP_W-1:0] c_op_xor = OP_W'(4);
    localparam logic [OP_W-1:0] c_op_not = OP_W'(5);
    localparam logic [OP_W-1:0] c_op_shl = OP_W'(6);
    localparam logic [OP_W-1:0] c_op_shr = OP_W'(7);
    localparam logic [OP_W-1:0] c_op_mul = OP_W'(8);
    localparam logic [OP_W-1:0] c_op_div = OP_W'(9);
    localparam logic [SH_W-1:0] c_last_iter = SH_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t              r_state;
    logic [SH_W-1:0]     r_count;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic [WIDTH-1:0]    r_b;
    logic [ADDR_W-1:0]   r_dest;
    logic                r_wb_we;
    logic [ADDR_W-1:0]   r_wb_dest;
    logic [WIDTH-1:0]    r_wb_data;
    logic                r_flag_z;
    logic                r_flag_c;

    logic [WIDTH:0]      w_add;
    logic [WIDTH:0]      w_sub;
    logic [WIDTH:0]      w_shl;
    logic [WIDTH:0]      w_shr;
    logic                w_sc_valid;
    logic [WIDTH-1:0]    w_sc_res;
    logic                w_sc_c;

    logic [WIDTH:0]      w_mul_sum;
    logic [WIDTH-1:0]    w_mul_hi_n;
    logic [WIDTH-1:0]    w_mul_lo_n;
    logic [WIDTH:0]      w_div_sh;
    logic [WIDTH:0]      w_div_tr;
    logic                w_div_ok;
    logic [WIDTH-1:0]    w_div_hi_n;
    logic [WIDTH-1:0]    w_div_lo_n;

    // Extra MSB/LSB on the shift operands catches the last bit shifted out.
    assign w_add = {1'b0, op_a} + {1'b0, op_b};
    assign w_sub = {1'b0, op_a} - {1'b0, op_b};
    assign w_shl = {1'b0, op_a} << op_b[SH_W-1:0];
    assign w_shr = {op_a, 1'b0} >> op_b[SH_W-1:0];

    always_comb begin
        w_sc_valid = 1'b1;
        w_sc_res   = '0;
        w_sc_c     = 1'b0;
        case (op)
            c_op_add: begin w_sc_res = w_add[WIDTH-1:0]; w_sc_c = w_add[WIDTH]; end
            c_op_sub: begin w_sc_res = w_sub[WIDTH-1:0]; w_sc_c = w_sub[WIDTH]; end
            c_op_and: w_sc_res = op_a & op_b;
            c_op_or:  w_sc_res = op_a | op_b;
            c_op_xor: w_sc_res = op_a ^ op_b;
            c_op_not: w_sc_res = ~op_a;
            c_op_shl: begin w_sc_res = w_shl[WIDTH-1:0]; w_sc_c = w_shl[WIDTH]; end
            c_op_shr: begin w_sc_res = w_shr[WIDTH:1];   w_sc_c = w_shr[0];     end
            default:  w_sc_valid = 1'b0;
        endcase
    end

    // MUL: {r_hi,r_lo} is the product register, multiplier starts in r_lo.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_hi_n = w_mul_sum[WIDTH:1];
    assign w_mul_lo_n = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // DIVU: r_hi is the partial remainder, dividend/quotient share r_lo.
    assign w_div_sh   = {r_hi, r_lo[WIDTH-1]};
    assign w_div_tr   = w_div_sh - {1'b0, r_b};
    assign w_div_ok   = ~w_div_tr[WIDTH];
    assign w_div_hi_n = w_div_ok ? w_div_tr[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    assign w_div_lo_n = {r_lo[WIDTH-2:0], w_div_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_dest    <= '0;
            r_wb_we   <= 1'b0;
            r_wb_dest <= '0;
            r_wb_data <= '0;
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
        end else begin
            r_wb_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op == c_op_mul || op == c_op_div) begin
                            r_state <= (op == c_op_mul) ? S_MUL : S_DIV;
                            r_count <= '0;
                            r_hi    <= '0;
                            r_lo    <= (op == c_op_mul) ? op_b : op_a;
                            r_b     <= (op == c_op_mul) ? op_a : op_b;
                            r_dest  <= dest;
                        end else if (w_sc_valid) begin
                            r_wb_we   <= 1'b1;
                            r_wb_dest <= dest;
                            r_wb_data <= w_sc_res;
                            r_flag_z  <= (w_sc_res == '0);
                            r_flag_c  <= w_sc_c;
                        end
                    end
                end
                S_MUL: begin
                    r_hi    <= w_mul_hi_n;
                    r_lo    <= w_mul_lo_n;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_last_iter) begin
                        r_state   <= S_IDLE;
                        r_wb_we   <= 1'b1;
                        r_wb_dest <= r_dest;
                        r_wb_data <= w_mul_lo_n;
                        r_flag_z  <= (w_mul_lo_n == '0);
                        r_flag_c  <= (w_mul_hi_n != '0);
                    end
                end
                S_DIV: begin
                    r_hi    <= w_div_hi_n;
                    r_lo    <= w_div_lo_n;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_last_iter) begin
                        r_state   <= S_IDLE;
                        r_wb_we   <= 1'b1;
                        r_wb_dest <= r_dest;
                        r_wb_data <= w_div_lo_n;
                        r_flag_z  <= (w_div_lo_n == '0);
                        r_flag_c  <= (r_b == '0);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign wb_we    = r_wb_we;
    assign wb_dest  = r_wb_dest;
    assign wb_data  = r_wb_data;
    assign flag_z   = r_flag_z;
    assign flag_c   = r_flag_c;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_stage
//  Description : Directed self-checking bench for alu_exec_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_exec_stage;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 4;
    localparam int OP_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OP_W-1:0]   op = '0;
    logic [WIDTH-1:0]  op_a = '0;
    logic [WIDTH-1:0]  op_b = '0;
    logic [ADDR_W-1:0] dest = '0;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_dest;
    logic [WIDTH-1:0]  wb_data;
    logic              busy;
    logic              flag_z;
    logic              flag_c;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_stage #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .OP_W(OP_W)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .op_a     (op_a),
        .op_b     (op_b),
        .dest     (dest),
        .wb_we    (wb_we),
        .wb_dest  (wb_dest),
        .wb_data  (wb_data),
        .busy     (busy),
        .flag_z   (flag_z),
        .flag_c   (flag_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] d, input logic v);
        op = o; op_a = a; op_b = b; dest = d; in_valid = v;
    endtask

    task automatic check_wb(input string tag, input logic [3:0] d, input logic [15:0] data,
                            input logic z, input logic c);
        chk({tag, "_we"},   32'(wb_we),   32'd1);
        chk({tag, "_dest"}, 32'(wb_dest), 32'(d));
        chk({tag, "_data"}, 32'(wb_data), 32'(data));
        chk({tag, "_z"},    32'(flag_z),  32'(z));
        chk({tag, "_c"},    32'(flag_c),  32'(c));
    endtask

    // Issue a single-cycle op from a negedge; returns at the negedge after the accept edge.
    task automatic single(input string tag, input logic [3:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] d,
                          input logic [15:0] data, input logic z, input logic c);
        drive(o, a, b, d, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check_wb(tag, d, data, z, c);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_multi(input string tag, input logic [3:0] o, input logic [15:0] a,
                             input logic [15:0] b, input logic [3:0] d,
                             input logic [15:0] data, input logic z, input logic c);
        int lat;
        int rdy_hi;
        lat = 0;
        rdy_hi = 0;
        drive(o, a, b, d, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        while (!wb_we && lat < 40) begin
            if (in_ready) rdy_hi++;
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd16);
        chk({tag, "_rdy_during"}, 32'(rdy_hi), 32'd0);
        check_wb(tag, d, data, z, c);
        chk({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        chk({tag, "_we_drop"}, 32'(wb_we), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_we",   32'(wb_we),    32'd0);
        chk("rst_dest", 32'(wb_dest),  32'd0);
        chk("rst_data", 32'(wb_data),  32'd0);
        chk("rst_z",    32'(flag_z),   32'd0);
        chk("rst_c",    32'(flag_c),   32'd0);
        chk("rst_rdy",  32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        single("add1", 4'd0, 16'h0005, 16'h0003, 4'd2, 16'h0008, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("hold_we",   32'(wb_we),   32'd0);
        chk("hold_data", 32'(wb_data), 32'h0008);

        // Back-to-back single-cycle ops
        drive(4'd0, 16'hFFFF, 16'h0001, 4'd3, 1'b1);
        @(posedge clk); @(negedge clk);
        check_wb("b2b_add", 4'd3, 16'h0000, 1'b1, 1'b1);
        drive(4'd1, 16'h0003, 16'h0005, 4'd5, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check_wb("b2b_sub", 4'd5, 16'hFFFE, 1'b0, 1'b1);

        single("and",  4'd2, 16'hF0F0, 16'hFF00, 4'd1, 16'hF000, 1'b0, 1'b0);
        single("or",   4'd3, 16'h00F0, 16'h0F00, 4'd1, 16'h0FF0, 1'b0, 1'b0);
        single("xor",  4'd4, 16'hAAAA, 16'hAAAA, 4'd0, 16'h0000, 1'b1, 1'b0);
        single("not",  4'd5, 16'h00FF, 16'h1234, 4'd6, 16'hFF00, 1'b0, 1'b0);
        single("shl1", 4'd6, 16'h8001, 16'h0001, 4'd7, 16'h0002, 1'b0, 1'b1);
        single("shl0", 4'd6, 16'h1234, 16'h0010, 4'd7, 16'h1234, 1'b0, 1'b0);
        single("shr1", 4'd7, 16'h0003, 16'h0001, 4'd8, 16'h0001, 1'b0, 1'b1);
        single("shr4", 4'd7, 16'h1238, 16'h0004, 4'd8, 16'h0123, 1'b0, 1'b1);

        // Multi-cycle ops
        run_multi("mul1", 4'd8, 16'h0123, 16'h0010, 4'd4, 16'h1230, 1'b0, 1'b0);
        run_multi("mul2", 4'd8, 16'h1000, 16'h0010, 4'd4, 16'h0000, 1'b1, 1'b1);
        run_multi("div1", 4'd9, 16'h0064, 16'h0007, 4'd9, 16'h000E, 1'b0, 1'b0);
        run_multi("div0", 4'd9, 16'h0005, 16'h0000, 4'd9, 16'hFFFF, 1'b0, 1'b1);

        // ADD held valid during MUL: accepted only after the MUL writeback
        drive(4'd8, 16'h0003, 16'h0005, 4'd4, 1'b1);
        @(posedge clk); @(negedge clk);
        drive(4'd0, 16'h0001, 16'h0002, 4'd7, 1'b1);
        lat = 0;
        while (!wb_we && lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk("hold_mul_lat", 32'(lat), 32'd16);
        check_wb("hold_mul", 4'd4, 16'h000F, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check_wb("hold_add", 4'd7, 16'h0003, 1'b0, 1'b0);
        pulses = 0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            if (wb_we) pulses++;
        end
        chk("hold_add_once", 32'(pulses), 32'd0);

        // Reset during MUL iteration 5
        drive(4'd8, 16'h0123, 16'h0010, 4'd4, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_we",   32'(wb_we),    32'd0);
        chk("mrst_dest", 32'(wb_dest),  32'd0);
        chk("mrst_data", 32'(wb_data),  32'd0);
        chk("mrst_z",    32'(flag_z),   32'd0);
        chk("mrst_c",    32'(flag_c),   32'd0);
        chk("mrst_rdy",  32'(in_ready), 32'd1);
        chk("mrst_busy", 32'(busy),     32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk); @(negedge clk);
            if (wb_we) pulses++;
        end
        chk("mrst_no_wb", 32'(pulses), 32'd0);

        // NOP leaves flags and writeback registers untouched
        single("pre_nop", 4'd0, 16'hFFFF, 16'h0001, 4'd1, 16'h0000, 1'b1, 1'b1);
        drive(4'hF, 16'h0005, 16'h0005, 4'd9, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("nop_we",   32'(wb_we),    32'd0);
        chk("nop_z",    32'(flag_z),   32'd1);
        chk("nop_c",    32'(flag_c),   32'd1);
        chk("nop_dest", 32'(wb_dest),  32'd1);
        chk("nop_rdy",  32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
